// File: rtl/lut_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
package lut_sweep_pkg;

  // Largest supported input count.
  localparam int unsigned N_MAX = 8;

  // State encodings kept as explicit constants so they stay bit-compatible with older code.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/lut_sweep_if.sv
// Configuration, control and row-stream signals of lut_sweep.
interface lut_sweep_if #(
  parameter int unsigned N = 3
);
  logic                 cfg_we;
  logic [(1<<N)-1:0]    cfg_mask;
  logic                 start;
  logic                 only_ones;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_x;
  logic                 out_s;
  logic                 busy;
  logic                 done;
  logic [N:0]           ones_count;

  // Configuration source / row consumer side.
  modport master (
    output cfg_we, cfg_mask, start, only_ones, out_ready,
    input  out_valid, out_x, out_s, busy, done, ones_count
  );

  // Sweeper side.
  modport slave (
    input  cfg_we, cfg_mask, start, only_ones, out_ready,
    output out_valid, out_x, out_s, busy, done, ones_count
  );
endinterface

// File: rtl/lut_sweep.sv
// N-input boolean function held as a minterm mask, swept row by row over a valid/ready stream.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int unsigned       N          = 3,
  parameter logic [(1<<N)-1:0] RESET_MASK = 8'h45
) (
  input  logic       clk,
  input  logic       rst,
  lut_sweep_if.slave io
);

  localparam logic [N:0] LAST = (N+1)'((1 << N) - 1);

  state_t            state;
  logic [N:0]        idx;
  logic [(1<<N)-1:0] mask;
  logic              mode;
  logic [N:0]        count;

  logic sweep;
  logic sel;
  logic valid;
  logic advance;
  logic last;

  // Row selection and step decision; everything here is a function of registers except
  // advance, which only feeds state updates, never an output.
  always_comb begin
    sweep   = (state == SWEEP);
    sel     = mask[idx[N-1:0]];
    valid   = sweep && (!mode || sel);
    advance = sweep && (!valid || io.out_ready);
    last    = (idx == LAST);
  end

  assign io.out_valid  = valid;
  assign io.out_x      = sweep ? idx[N-1:0] : '0;
  assign io.out_s      = sweep & sel;
  assign io.busy       = sweep;
  assign io.done       = (state == DONE);
  assign io.ones_count = count;

  // FSM, mask register, row index and ones counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      mask  <= RESET_MASK;
      mode  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.cfg_we) mask <= io.cfg_mask;
          if (io.start) begin
            mode  <= io.only_ones;
            idx   <= '0;
            count <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (advance) begin
            if (valid && sel) count <= count + 1'b1;
            if (last) state <= DONE;
            else      idx   <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep.sv
// Randomised self-checking bench for lut_sweep against a row-list reference model.
module tb_lut_sweep;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  lut_sweep_if #(.N(3)) io ();

  lut_sweep #(.N(3), .RESET_MASK(8'h45)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // 0: always ready, 1: pattern 1,0,0 repeating, otherwise random.
  function automatic logic ready_at(input int rpat, input int c);
    if (rpat == 0) return 1'b1;
    if (rpat == 1) return ((c - 1) % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic write_mask(input logic [7:0] m);
    @(posedge clk); #1;
    io.cfg_we   = 1'b1;
    io.cfg_mask = m;
    @(posedge clk); #1;
    io.cfg_we   = 1'b0;
  endtask

  // Expected behaviour: rows are the indices 0..7 in order (only those with f=1 in ones
  // mode); ones_count is the number of ones in the mask; done arrives 2^N+1 cycles after
  // start plus one cycle per stalled row.
  task automatic run_sweep(input logic [7:0] m, input logic mode, input int rpat,
                           input logic same_edge_cfg, input logic mid_cfg);
    int   q[$];
    int   exp_ones = 0;
    int   stalls   = 0;
    int   c        = 1;
    int   done_c   = -1;
    logic prev_stall = 1'b0;
    logic [2:0] prev_x = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) exp_ones++;
      if (!mode || m[i]) q.push_back(i);
    end
    @(posedge clk); #1;
    io.start     = 1'b1;
    io.only_ones = mode;
    if (same_edge_cfg) begin
      io.cfg_we   = 1'b1;
      io.cfg_mask = m;
    end
    @(posedge clk); #1;
    io.start     = 1'b0;
    io.cfg_we    = 1'b0;
    io.only_ones = ~mode;
    while (c <= 200) begin
      io.out_ready = ready_at(rpat, c);
      if (mid_cfg && c == 3) begin
        io.cfg_we   = 1'b1;
        io.cfg_mask = ~m;
      end else begin
        io.cfg_we   = 1'b0;
      end
      @(negedge clk);
      if (io.done) begin
        done_c = c;
        check_val("busy_in_done", io.busy, 0);
        break;
      end
      check_val("busy", io.busy, 1);
      if (io.out_valid) begin
        if (prev_stall) check_val("stall_stable_x", io.out_x, prev_x);
        if (q.size() == 0) begin
          check_val("unexpected_row", io.out_x, 8);
        end else begin
          check_val("row_x", io.out_x, q[0]);
          check_val("row_s", io.out_s, m[q[0]]);
        end
        prev_x = io.out_x;
        if (io.out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    io.cfg_we    = 1'b0;
    io.out_ready = 1'b1;
    check_val("done_cycle", done_c, 9 + stalls);
    check_val("rows_left", q.size(), 0);
    check_val("ones_count", io.ones_count, exp_ones);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("done_one_cycle", io.done, 0);
    check_val("idle_busy", io.busy, 0);
    check_val("ones_count_hold", io.ones_count, exp_ones);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, io.out_valid, 0);
    check_val({tag, "_busy"}, io.busy, 0);
    check_val({tag, "_done"}, io.done, 0);
    check_val({tag, "_x"}, io.out_x, 0);
    check_val({tag, "_s"}, io.out_s, 0);
    check_val({tag, "_count"}, io.ones_count, 0);
  endtask

  initial begin
    logic [7:0] m;
    logic       mode;
    logic       hit;
    rst          = 1'b1;
    io.cfg_we    = 1'b0;
    io.cfg_mask  = '0;
    io.start     = 1'b0;
    io.only_ones = 1'b0;
    io.out_ready = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(8'h45, 1'b0, 0, 1'b0, 1'b0);
    run_sweep(8'h45, 1'b1, 0, 1'b0, 1'b0);
    write_mask(8'h00);
    run_sweep(8'h00, 1'b1, 0, 1'b0, 1'b0);
    write_mask(8'hFF);
    run_sweep(8'hFF, 1'b0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      m    = 8'($urandom);
      mode = 1'($urandom_range(0, 1));
      write_mask(m);
      run_sweep(m, mode, 2, 1'b0, 1'b0);
    end

    run_sweep(8'h80, 1'b0, 0, 1'b1, 1'b1);

    // Reset in the middle of row 4.
    @(posedge clk); #1;
    io.start     = 1'b1;
    io.only_ones = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (io.out_valid && io.out_x == 3'd4) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("row4_reached", hit, 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("held_reset");
    rst = 1'b0;
    run_sweep(8'h45, 1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_sweep.md
# lut_sweep

Parametrised N-input boolean function unit with a sequential truth-table sweeper. The function is held as a 2^N-bit minterm mask; on `start` the block steps through every input combination and emits each result over a valid/ready stream, optionally only the combinations where the function is 1, and counts the ones. It sits between a configuration source and a logger or checker consuming truth-table rows.

## Interface
Parameters:
- `N`, 3: number of function inputs; legal range 1..8.
- `RESET_MASK`, 8'h45 (for N=3): mask value loaded at reset; width 2^N. Bit i is f(i), where i = {x_(N-1)..x_0} and the MSB is the first input.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `cfg_we` in 1: write `cfg_mask` into the mask register; honoured only in IDLE.
- `cfg_mask` in 2^N: new function mask.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `only_ones` in 1: sampled with `start`; 1 = emit only rows with f=1.
- `out_valid` out 1: row available.
- `out_ready` in 1: consumer accepts the row.
- `out_x` out N: input combination of the current row.
- `out_s` out 1: f(`out_x`).
- `busy` out 1: high in SWEEP.
- `done` out 1: one-cycle pulse after the last row.
- `ones_count` out N+1: number of emitted rows with `out_s`=1 in the current or last sweep.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE:
  - `cfg_we`=1 writes the mask.
  - `start`=1 latches `only_ones` into `mode`, sets idx=0, clears `ones_count`, and moves to SWEEP.
  - `cfg_we` and `start` may be asserted on the same edge; both are accepted and the sweep uses the new mask.
- SWEEP, full mode (`mode`=0):
  - `out_valid`=1, `out_x`=idx, `out_s`=mask[idx].
  - On a transfer (`out_valid` & `out_ready`), idx increments and `ones_count` increments if `out_s`=1.
- SWEEP, ones mode (`mode`=1):
  - If mask[idx]=0: `out_valid`=0 and idx increments, one cycle per skipped index.
  - Otherwise: behaves as full mode.
- Leaving SWEEP: transfer or skip at idx=2^N-1 → DONE. idx never wraps.
- DONE: `done`=1 for exactly one cycle, then IDLE. `ones_count` holds until the next accepted `start`.
- Handshake rules:
  - Once `out_valid` is asserted, `out_x` and `out_s` stay stable until the transfer.
  - `out_valid` never depends combinationally on `out_ready`.
- While not in IDLE: `cfg_we` and `start` are ignored and the mask is frozen.
- `rst` at any time, including mid-sweep:
  - mask = `RESET_MASK`, state IDLE, idx=0, `mode`=0, `ones_count`=0.
  - `out_valid`, `busy`, `done` = 0; `out_x`=0, `out_s`=0.
- Arithmetic:
  - idx is N+1 bits internally so the terminal compare at 2^N-1 cannot overflow.
  - `ones_count` saturates naturally at 2^N, which fits in N+1 bits.

## Timing
- All outputs are driven from registers (state, idx, mask, mode, count) through mux logic only; there is no input-to-output combinational path.
- Full mode, `start` sampled at edge k:
  - `busy`=1 and first `out_valid` from cycle k+1.
  - With `out_ready` held high, one row per cycle; last row in cycle k+2^N.
  - `done` in cycle k+2^N+1; IDLE (new `start` accepted) in cycle k+2^N+2.
- Ones mode: the sweep always takes exactly 2^N SWEEP cycles plus the backpressure stall cycles.
- Backpressure: each cycle with `out_valid`=1 and `out_ready`=0 adds one cycle and changes nothing.

## Structure
- Package `lut_sweep_pkg`: `state_t` enum (IDLE, SWEEP, DONE) and the `N_MAX`=8 constant.
- One module. Mask register, idx counter, count register and FSM live together.
- No sub-module is warranted; the row select is a single indexed mask bit.

## Test plan
- Reset mask, full sweep, `out_ready`=1:
  - rows `out_x`=0..7 with `out_s`=1,0,1,0,0,0,1,0.
  - `ones_count`=3; `done` exactly 2^N+1 cycles after `start`.
- Reset mask, `only_ones`=1:
  - rows `out_x`=0,2,6 only; `done` in the same cycle as the full sweep.
- `cfg_mask`=8'h00 with `only_ones`=1:
  - no `out_valid` at all; `done` after 8 SWEEP cycles; `ones_count`=0.
- `cfg_mask`=8'hFF, `out_ready` toggling 1,0,0,1,...:
  - row data stable while stalled; 8 rows delivered in order; `ones_count`=8.
- `cfg_we`=1 (mask 8'h80) and `start` on the same edge:
  - mask updates and the sweep uses 8'h80 (only row 7 has `out_s`=1).
  - `cfg_we` mid-sweep has no effect.
- `rst` pulse during row 4:
  - all outputs zero, mask back to 8'h45, IDLE.
  - a following `start` sweeps normally from row 0.
